fir_stream_ctrl: RTL and testbench



---
 rtl/fir_stream_ctrl.sv | 141 ++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_ctrl.sv
// Stream-side controller for the systolic FIR tap chain: feeds samples to the array,
// tracks in-flight samples with a tag pipeline and buffers results in a small FIFO.
module fir_stream_ctrl #(
   parameter int unsigned DW    = 32,
   parameter int unsigned LAT   = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DW-1:0]             s_data,
   input  logic                      flush,
   output logic                      arr_en,
   output logic [DW-1:0]             arr_x,
   input  logic [DW-1:0]             arr_y,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DW-1:0]             m_data,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      flush_done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(LAT + 1);

   typedef enum logic [0:0] {StRun, StDrain} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic [LAT:1]    tag_q, tag_d;

   logic [DW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [AW:0]     level_q, level_d;

   logic            accept;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;

   assign full  = (level_q == (AW + 1)'(DEPTH));
   assign empty = (level_q == '0);

   // Outputs are forced idle while rst is held so the port looks quiet during reset.
   always_comb begin
      s_ready = 1'b0;
      accept  = 1'b0;
      arr_en  = 1'b0;
      arr_x   = '0;
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StRun: begin
               s_ready = !full;
               accept  = s_valid && !full;
               arr_en  = accept;
               arr_x   = accept ? s_data : '0;
               if (flush) begin
                  state_d = StDrain;
                  cnt_d   = CW'(LAT);
               end
            end
            StDrain: begin
               arr_en = !full;
               if (arr_en) begin
                  cnt_d = cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     state_d = StRun;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

   // Tags advance only with the array, so they stay aligned with the chain contents.
   always_comb begin
      tag_d = tag_q;
      if (arr_en) begin
         tag_d[1] = accept;
         for (int i = 2; i <= int'(LAT); i++) begin
            tag_d[i] = tag_q[i-1];
         end
      end
   end

   assign push = arr_en && tag_q[LAT];
   assign pop  = m_valid && m_ready;

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + (AW + 1)'(1);
         2'b01:   level_d = level_q - (AW + 1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         tag_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         tag_q   <= tag_d;
         level_q <= level_d;
         if (push) begin
            wr_q <= wr_q + AW'(1);
         end
         if (pop) begin
            rd_q <= rd_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q] <= arr_y;
      end
   end

   assign m_valid    = !empty;
   assign m_data     = empty ? '0 : mem_q[rd_q];
   assign level      = level_q;
   assign flush_done = done_q;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench for fir_stream_ctrl: behavioural tap-chain model plus an
// in-order result scoreboard.
module tb_fir_stream_ctrl;

   localparam int DW    = 32;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          flush;
   logic          arr_en;
   logic [DW-1:0] arr_x;
   logic [DW-1:0] arr_y;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [LW-1:0] level;
   logic          flush_done;

   fir_stream_ctrl #(
      .DW    (DW),
      .LAT   (LAT),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .flush      (flush),
      .arr_en     (arr_en),
      .arr_x      (arr_x),
      .arr_y      (arr_y),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .level      (level),
      .flush_done (flush_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Array model: LAT-deep shift of arr_x advanced by arr_en, sampled mid-cycle.
   logic [DW-1:0] pipe [LAT];
   logic          en_s = 1'b0;
   logic [DW-1:0] x_s  = '0;
   initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
   always @(posedge clk) begin
      if (en_s) begin
         pipe[0] <= x_s;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign arr_y = pipe[LAT-1];

   // Scoreboard and event counters, sampled on the falling edge.
   logic [DW-1:0] exp_q [$];
   int en_cnt   = 0;
   int done_cnt = 0;
   always @(negedge clk) begin
      en_s = arr_en;
      x_s  = arr_x;
      if (arr_en) en_cnt++;
      if (flush_done) done_cnt++;
      if (s_valid && s_ready) begin
         check_eq("arr_x_on_accept", arr_x, s_data);
         exp_q.push_back(s_data);
      end
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) check_eq("spurious_result", 1, 0);
         else check_eq("result", m_data, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int first, input int count, input int max_cyc, output int acc);
      int v;
      v   = first;
      acc = 0;
      for (int c = 0; c < max_cyc && acc < count; c++) begin
         s_valid = 1'b1;
         s_data  = DW'(v);
         if (s_ready) begin
            acc++;
            v++;
         end
         step();
      end
      s_data = DW'(v);
   endtask

   task automatic wait_done(input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cyc && !seen; c++) begin
         if (flush_done) seen = 1'b1;
         else step();
      end
      check_eq("flush_done_seen", seen, 1);
   endtask

   task automatic wait_idle(input int max_cyc);
      for (int c = 0; c < max_cyc; c++) begin
         if (exp_q.size() == 0 && !m_valid) break;
         step();
      end
      check_eq("drained", exp_q.size(), 0);
   endtask

   int acc;
   int ebase;
   int dbase;
   int maxl;

   initial begin
      s_valid = 1'b0;
      s_data  = '0;
      flush   = 1'b0;
      m_ready = 1'b0;

      // Reset behaviour
      #23;
      check_eq("rst_s_ready", s_ready, 0);
      check_eq("rst_arr_en", arr_en, 0);
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_level", level, 0);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_flush_done", flush_done, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_eq("post_rst_s_ready", s_ready, 1);
      check_eq("post_rst_arr_en", arr_en, 0);

      // Stream 10..50 with flush on the last sample
      m_ready = 1'b1;
      ebase   = en_cnt;
      maxl    = 0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(10 * (i + 1));
         flush   = (i == 4);
         step();
         if (int'(level) > maxl) maxl = int'(level);
         check_eq("stream_m_valid", m_valid, (i >= 3) ? 1 : 0);
         if (i == 3) check_eq("first_result", m_data, 10);
         if (i == 4) check_eq("second_result", m_data, 20);
      end
      s_valid = 1'b0;
      flush   = 1'b0;
      check_eq("stream_adv_count", en_cnt - ebase, 5);
      for (int b = 0; b < LAT; b++) begin
         check_eq("drain_s_ready", s_ready, 0);
         check_eq("drain_arr_en", arr_en, 1);
         check_eq("drain_arr_x", arr_x, 0);
         check_eq("drain_no_done", flush_done, 0);
         step();
         if (int'(level) > maxl) maxl = int'(level);
      end
      check_eq("flush_done_pulse", flush_done, 1);
      check_eq("s_ready_after_drain", s_ready, 1);
      step();
      check_eq("flush_done_single", flush_done, 0);
      wait_idle(20);
      check_eq("stream_level_max", maxl, 1);

      // Backpressure fills FIFO plus pipeline, then resumes
      m_ready = 1'b0;
      offer(1, 10, 15, acc);
      check_eq("bp_accepted", acc, 7);
      check_eq("bp_level", level, 4);
      check_eq("bp_s_ready", s_ready, 0);
      check_eq("bp_arr_en", arr_en, 0);
      m_ready = 1'b1;
      offer(8, 3, 20, acc);
      s_valid = 1'b0;
      check_eq("bp_resume_accepted", acc, 3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_done(20);
      wait_idle(20);

      // Flush while FIFO is full: drain must stall
      m_ready = 1'b0;
      offer(11, 10, 15, acc);
      s_valid = 1'b0;
      check_eq("full_accepted", acc, 7);
      flush = 1'b1;
      step();
      flush = 1'b0;
      dbase = done_cnt;
      for (int c = 0; c < 5; c++) begin
         check_eq("stall_arr_en", arr_en, 0);
         check_eq("stall_level", level, 4);
         check_eq("stall_no_done", flush_done, 0);
         step();
      end
      check_eq("stall_done_count", done_cnt - dbase, 0);
      m_ready = 1'b1;
      ebase   = en_cnt;
      wait_done(20);
      check_eq("stall_bubbles", en_cnt - ebase, LAT);
      wait_idle(20);
      check_eq("stall_done_once", done_cnt - dbase, 1);

      // Flush on an empty pipeline
      ebase = en_cnt;
      dbase = done_cnt;
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check_eq("empty_flush_m_valid", m_valid, 0);
         step();
      end
      check_eq("empty_flush_bubbles", en_cnt - ebase, LAT);
      check_eq("empty_flush_done", done_cnt - dbase, 1);

      // Reset asserted during DRAIN discards in-flight samples
      m_ready = 1'b0;
      offer(100, 2, 2, acc);
      s_valid = 1'b0;
      check_eq("pre_rst_accepted", acc, 2);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      check_eq("midrst_s_ready", s_ready, 0);
      check_eq("midrst_arr_en", arr_en, 0);
      check_eq("midrst_m_valid", m_valid, 0);
      check_eq("midrst_level", level, 0);
      check_eq("midrst_m_data", m_data, 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      m_ready = 1'b1;
      #1;
      check_eq("after_rst_s_ready", s_ready, 1);
      for (int c = 0; c < 8; c++) begin
         check_eq("after_rst_no_result", m_valid, 0);
         check_eq("after_rst_arr_en", arr_en, 0);
         step();
      end
      check_eq("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
